// File: rtl/elevator_floor_ctrl.sv
// Floor-sequencing controller for a 3-floor elevator.
// Latches call buttons into a pending register and serves them with a
// direction-preserving (SCAN) state machine. One shared timer measures both
// floor-to-floor travel and door dwell. All outputs come from registered state.
module elevator_floor_ctrl #(
    parameter int TRAVEL_CYCLES = 50000000,
    parameter int DOOR_CYCLES   = 100000000,
    parameter int CNT_W         = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] call_btn,
    output logic [1:0] floor_out,
    output logic       motor_up,
    output logic       motor_down,
    output logic       door_open,
    output logic [2:0] pending
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    state_t             state_q, state_d;
    dir_t               dir_q, dir_d;
    logic [1:0]         floor_q, floor_d;
    logic [2:0]         pend_q, pend_d;
    logic [CNT_W-1:0]   timer_q, timer_d;

    logic [2:0]         here_mask;
    logic [2:0]         up_mask;
    logic [2:0]         down_mask;
    logic [1:0]         floor_up;
    logic [1:0]         floor_down;
    logic               req_here;
    logic               req_above;
    logic               req_below;
    logic               above_after_up;
    logic               below_after_down;
    logic               travel_done;
    logic               door_done;
    logic               door_call;

    // Request summaries relative to the current floor and to the floor the
    // car is about to reach; decisions use only the latched pending register.
    always_comb begin
        floor_up         = floor_q + 2'd1;
        floor_down       = floor_q - 2'd1;
        here_mask        = 3'b001 << floor_q;
        up_mask          = 3'b001 << floor_up;
        down_mask        = 3'b001 << floor_down;
        req_here         = |(pend_q & here_mask);
        req_above        = 1'b0;
        req_below        = 1'b0;
        case (floor_q)
            2'd0: req_above = |pend_q[2:1];
            2'd1: begin
                req_above = pend_q[2];
                req_below = pend_q[0];
            end
            2'd2: req_below = |pend_q[1:0];
            default: begin
                req_above = 1'b0;
                req_below = 1'b0;
            end
        endcase
        // Moving up always lands on floor 1 or 2; only floor 1 has anything above.
        above_after_up   = (floor_up == 2'd1) & pend_q[2];
        // Moving down always lands on floor 1 or 0; only floor 1 has anything below.
        below_after_down = (floor_down == 2'd1) & pend_q[0];
        travel_done      = (timer_q == CNT_W'(TRAVEL_CYCLES - 1));
        door_done        = (timer_q == CNT_W'(DOOR_CYCLES - 1));
        door_call        = |(call_btn & here_mask);
    end

    // Next-state logic: request latch, SCAN decisions, travel and door timing.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        floor_d = floor_q;
        timer_d = timer_q;
        pend_d  = pend_q | call_btn;
        // A call for the floor whose door is already open just extends dwell.
        if (state_q == DOOR_OPEN) begin
            pend_d = pend_q | (call_btn & ~here_mask);
        end

        case (state_q)
            IDLE: begin
                if (req_here) begin
                    state_d = DOOR_OPEN;
                    pend_d  = pend_d & ~here_mask;
                    timer_d = '0;
                end else if (req_above && (dir_q == DIR_UP || !req_below)) begin
                    state_d = MOVE_UP;
                    dir_d   = DIR_UP;
                    timer_d = '0;
                end else if (req_below) begin
                    state_d = MOVE_DOWN;
                    dir_d   = DIR_DOWN;
                    timer_d = '0;
                end
            end
            MOVE_UP: begin
                if (travel_done) begin
                    floor_d = floor_up;
                    timer_d = '0;
                    if (|(pend_q & up_mask)) begin
                        state_d = DOOR_OPEN;
                        pend_d  = pend_d & ~up_mask;
                    end else if (!above_after_up) begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            MOVE_DOWN: begin
                if (travel_done) begin
                    floor_d = floor_down;
                    timer_d = '0;
                    if (|(pend_q & down_mask)) begin
                        state_d = DOOR_OPEN;
                        pend_d  = pend_d & ~down_mask;
                    end else if (!below_after_down) begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            DOOR_OPEN: begin
                if (door_call) begin
                    timer_d = '0;
                end else if (door_done) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase

        // Floor code 11 is not a real floor; recover to the ground floor.
        if (floor_q == 2'b11) begin
            floor_d = 2'b00;
            state_d = IDLE;
            timer_d = '0;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= DIR_UP;
            floor_q <= 2'b00;
            pend_q  <= 3'b000;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            floor_q <= floor_d;
            pend_q  <= pend_d;
            timer_q <= timer_d;
        end
    end

    assign floor_out  = floor_q;
    assign pending    = pend_q;
    assign motor_up   = (state_q == MOVE_UP);
    assign motor_down = (state_q == MOVE_DOWN);
    assign door_open  = (state_q == DOOR_OPEN);

endmodule

// File: tb/tb_elevator_floor_ctrl.sv
// Bench for elevator_floor_ctrl: directed scenarios followed by random calls,
// every cycle compared against a countdown-based behavioural model.
module tb_elevator_floor_ctrl;

    localparam int TRAVEL = 4;
    localparam int DOOR   = 3;

    localparam int PH_IDLE = 0;
    localparam int PH_UP   = 1;
    localparam int PH_DOWN = 2;
    localparam int PH_DOOR = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] call_btn;
    logic [1:0] floor_out;
    logic       motor_up;
    logic       motor_down;
    logic       door_open;
    logic [2:0] pending;

    int tests = 0;
    int fails = 0;

    // Model: floor number, activity, cycles left in the activity, sweep direction.
    int  m_floor = 0;
    int  m_phase = PH_IDLE;
    int  m_left  = 0;
    bit  m_dir_up = 1'b1;
    bit  m_req[3] = '{1'b0, 1'b0, 1'b0};

    elevator_floor_ctrl #(
        .TRAVEL_CYCLES(TRAVEL),
        .DOOR_CYCLES  (DOOR),
        .CNT_W        (27)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .call_btn  (call_btn),
        .floor_out (floor_out),
        .motor_up  (motor_up),
        .motor_down(motor_down),
        .door_open (door_open),
        .pending   (pending)
    );

    // Clock generation.
    always #5 clk = ~clk;

    function automatic bit any_above(input int f);
        bit r = 1'b0;
        for (int j = f + 1; j < 3; j++) r |= m_req[j];
        return r;
    endfunction

    function automatic bit any_below(input int f);
        bit r = 1'b0;
        for (int j = 0; j < f; j++) r |= m_req[j];
        return r;
    endfunction

    task automatic model_step(input logic [2:0] c, input logic r);
        bit nxt[3];
        bit restart;
        if (!r) begin
            m_floor  = 0;
            m_phase  = PH_IDLE;
            m_left   = 0;
            m_dir_up = 1'b1;
            m_req    = '{1'b0, 1'b0, 1'b0};
            return;
        end
        restart = 1'b0;
        for (int i = 0; i < 3; i++) nxt[i] = m_req[i] | c[i];
        if (m_phase == PH_DOOR && c[m_floor]) begin
            nxt[m_floor] = m_req[m_floor];
            restart = 1'b1;
        end
        case (m_phase)
            PH_IDLE: begin
                if (m_req[m_floor]) begin
                    m_phase = PH_DOOR;
                    m_left  = DOOR;
                    nxt[m_floor] = 1'b0;
                end else if (any_above(m_floor) && (m_dir_up || !any_below(m_floor))) begin
                    m_phase  = PH_UP;
                    m_dir_up = 1'b1;
                    m_left   = TRAVEL;
                end else if (any_below(m_floor)) begin
                    m_phase  = PH_DOWN;
                    m_dir_up = 1'b0;
                    m_left   = TRAVEL;
                end
            end
            PH_UP, PH_DOWN: begin
                m_left--;
                if (m_left == 0) begin
                    m_floor = (m_phase == PH_UP) ? m_floor + 1 : m_floor - 1;
                    if (m_req[m_floor]) begin
                        m_phase = PH_DOOR;
                        m_left  = DOOR;
                        nxt[m_floor] = 1'b0;
                    end else if (m_phase == PH_UP && any_above(m_floor)) begin
                        m_left = TRAVEL;
                    end else if (m_phase == PH_DOWN && any_below(m_floor)) begin
                        m_left = TRAVEL;
                    end else begin
                        m_phase = PH_IDLE;
                    end
                end
            end
            default: begin
                if (restart) begin
                    m_left = DOOR;
                end else begin
                    m_left--;
                    if (m_left == 0) m_phase = PH_IDLE;
                end
            end
        endcase
        m_req = nxt;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // One clock: drive inputs after the falling edge, advance the model on the
    // rising edge, then compare shortly after it.
    task automatic tick(input logic [2:0] c, input logic r);
        logic [2:0] exp_pend;
        @(negedge clk);
        call_btn = c;
        rst_n    = r;
        @(posedge clk);
        model_step(c, r);
        #1;
        exp_pend = {m_req[2], m_req[1], m_req[0]};
        chk("floor_out",  32'(floor_out),  32'(m_floor));
        chk("pending",    32'(pending),    32'(exp_pend));
        chk("motor_up",   32'(motor_up),   32'(m_phase == PH_UP));
        chk("motor_down", 32'(motor_down), 32'(m_phase == PH_DOWN));
        chk("door_open",  32'(door_open),  32'(m_phase == PH_DOOR));
        chk("exclusive",  32'($countones({motor_up, motor_down, door_open}) <= 1), 32'd1);
    endtask

    task automatic idle_ticks(input int n);
        for (int k = 0; k < n; k++) tick(3'b000, 1'b1);
    endtask

    initial begin
        rst_n    = 1'b0;
        call_btn = 3'b000;

        // Reset held with all buttons pressed, then release with no calls.
        tick(3'b111, 1'b0);
        tick(3'b111, 1'b0);
        idle_ticks(3);

        // Single call to floor 3 from floor 1.
        tick(3'b100, 1'b1);
        idle_ticks(18);

        // Return to floor 1.
        tick(3'b001, 1'b1);
        idle_ticks(18);

        // Intermediate stop at floor 2 picked up during the first segment.
        tick(3'b100, 1'b1);
        tick(3'b000, 1'b1);
        tick(3'b010, 1'b1);
        idle_ticks(25);

        // Park at floor 2 with direction up: go to floor 1, then up to floor 2.
        tick(3'b001, 1'b1);
        idle_ticks(18);
        tick(3'b010, 1'b1);
        idle_ticks(12);

        // SCAN: calls above and below in the same cycle, up wins.
        tick(3'b101, 1'b1);
        idle_ticks(35);

        // Door restart at floor 1 when the dwell timer has reached 2.
        tick(3'b001, 1'b1);
        idle_ticks(3);
        tick(3'b001, 1'b1);
        idle_ticks(6);

        // Reset while travelling up with the timer at 2.
        tick(3'b100, 1'b1);
        idle_ticks(3);
        tick(3'b000, 1'b0);
        idle_ticks(2);

        // Random calls with occasional resets.
        for (int n = 0; n < 600; n++) begin
            logic [2:0] c;
            logic       r;
            c = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            r = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            tick(c, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/elevator_floor_ctrl.md
Name: elevator_floor_ctrl

Overview:
- Floor-sequencing controller for the 3-floor elevator; sits directly upstream of the floor 7-segment decoder.
- Latches hall/cabin call buttons and runs a direction-preserving (SCAN) state machine.
- Times floor-to-floor travel and door dwell with an internal counter.
- Drives the 2-bit current-floor code consumed by the decoder, plus motor and door outputs.

Parameters:
- TRAVEL_CYCLES, 50000000, clock cycles to travel one floor (1 s at 50 MHz).
- DOOR_CYCLES, 100000000, clock cycles the door stays open (2 s at 50 MHz).
- CNT_W, 27, timer width; must hold max(TRAVEL_CYCLES, DOOR_CYCLES)-1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- call_btn  in  3  request per floor, active-high; bit0=floor 1, bit1=floor 2, bit2=floor 3; any pulse width >=1 cycle.
- floor_out  out  2  current floor to the 7-seg decoder: 00=floor 1, 01=floor 2, 10=floor 3; 11 never driven.
- motor_up  out  1  high while moving up.
- motor_down  out  1  high while moving down.
- door_open  out  1  high while door is open.
- pending  out  3  latched outstanding requests, same bit mapping as call_btn (for LEDs).

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- All outputs are registered or decoded from registered state. No combinational path from call_btn to any output.
- Reset (rst_n=0 at an edge):
  - state=IDLE, floor_out=00, pending=000, timer=0, dir=UP.
  - motor_up=motor_down=door_open=0.
  - Reset mid-travel or mid-door aborts immediately; no floor advance.
- Request latch: at each edge, pending[i] <= pending[i] | call_btn[i], with two exceptions:
  - DOOR_OPEN with floor_out==i: bit not set; the door timer restarts to 0 instead.
  - Arrival edge into DOOR_OPEN at floor i: pending[i] cleared. Clear wins over a simultaneous call_btn[i].
- States:
  - IDLE: evaluates the pending register only, never raw call_btn. Latency from call to action is therefore 2 edges. Priority order:
    1. pending[cur] -> DOOR_OPEN; clear pending[cur]; timer=0.
    2. Requests above and (dir==UP or none below) -> MOVE_UP; dir=UP; timer=0.
    3. Requests below -> MOVE_DOWN; dir=DOWN; timer=0.
    4. Otherwise stay IDLE.
  - MOVE_UP: motor_up=1; timer increments each cycle. When timer==TRAVEL_CYCLES-1:
    - floor_out+1 and timer=0 on the same edge.
    - Then: pending[new] -> DOOR_OPEN (clear pending[new]); else requests above new floor -> stay MOVE_UP; else -> IDLE.
  - MOVE_DOWN: mirror of MOVE_UP with floor_out-1.
  - DOOR_OPEN: door_open=1; timer increments. At timer==DOOR_CYCLES-1 -> IDLE, timer=0.
- Motor/door exclusivity: at most one of motor_up, motor_down, door_open is high in any cycle. Door never opens while moving.
- Range bounds:
  - Never MOVE_UP from floor 10 or MOVE_DOWN from floor 00. These are guarded by the "requests above/below" terms, which are empty at the ends.
  - 11 is unreachable; if ever present, force floor_out=00, state IDLE.
- Timing: one floor of travel = exactly TRAVEL_CYCLES cycles with the motor high. Door dwell = DOOR_CYCLES cycles unless restarted.
- Simultaneous calls above and below while IDLE: the current dir wins (SCAN). Initial dir after reset is UP.

Test Plan (override TRAVEL_CYCLES=4, DOOR_CYCLES=3):
- Reset: hold rst_n=0 for 2 cycles with call_btn=111 -> floor_out=00, pending=000, all motor/door outputs 0. After release with call_btn=000, everything stays idle.
- Single call: pulse call_btn=100 for 1 cycle at floor 00 ->
  - pending=100 after 1 edge; motor_up rises 1 edge later.
  - floor_out 00->01 after 4 motor cycles, then 01->10 after 4 more.
  - At arrival, door_open=1 for 3 cycles and pending=000; then IDLE.
- Intermediate stop: at floor 00 pulse 100; during the first travel segment pulse 010 -> stops at 01 with door 3 cycles and pending=100, then continues up to 10.
- SCAN priority: at floor 01, dir=UP, idle, pulse 001 and 100 in the same cycle -> goes up to 10 first, then down to 00. Exclusivity holds throughout.
- Door restart: at floor 00 during DOOR_OPEN with timer=2, pulse call_btn=001 -> pending[0] stays 0 and door stays open 3 more cycles.
- Reset mid-travel: assert rst_n=0 while motor_up=1 and timer=2 -> next edge floor_out=00, motor_up=0, pending=000.
